// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter bus bundle: pipeline MEM side, debug/loader side,
// and the shared data-memory port.
interface dmem_arbiter_if #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9
);
    logic                  p_rd;
    logic                  p_wr;
    logic [DM_ADDRESS-1:0] p_addr;
    logic [DATA_W-1:0]     p_wdata;
    logic [2:0]            p_funct3;
    logic [DATA_W-1:0]     p_rdata;
    logic                  p_stall;

    logic                  d_req;
    logic                  d_we;
    logic [DM_ADDRESS-1:0] d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_rvalid;

    logic                  m_rd;
    logic                  m_wr;
    logic [DM_ADDRESS-1:0] m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [2:0]            m_funct3;
    logic [DATA_W-1:0]     m_rdata;

    modport slave (
        input  p_rd, p_wr, p_addr, p_wdata, p_funct3,
        input  d_req, d_we, d_addr, d_wdata,
        input  m_rdata,
        output p_rdata, p_stall,
        output d_gnt, d_rdata, d_rvalid,
        output m_rd, m_wr, m_addr, m_wdata, m_funct3
    );

    modport master (
        output p_rd, p_wr, p_addr, p_wdata, p_funct3,
        output d_req, d_we, d_addr, d_wdata,
        output m_rdata,
        input  p_rdata, p_stall,
        input  d_gnt, d_rdata, d_rvalid,
        input  m_rd, m_wr, m_addr, m_wdata, m_funct3
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: pipeline has fixed priority, debug gets a
// forced one-cycle slot after STARVE_MAX consecutive blocked cycles.
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              p_act, d_own, p_own, stall;

    // Port ownership: FORCE hands the slot to a waiting debug request.
    always_comb begin
        p_act = bus.p_rd | bus.p_wr;
        if (state_q == FORCE) begin
            d_own = bus.d_req;
            stall = bus.d_req & p_act;
        end else begin
            d_own = bus.d_req & ~p_act;
            stall = 1'b0;
        end
        p_own = p_act & ~d_own;
    end

    // Starvation counting; reaching STARVE_MAX arms one forced slot.
    always_comb begin
        state_d = NORMAL;
        cnt_d   = '0;
        cnt_inc = cnt_q + 1'b1;
        if (bus.d_req & ~d_own) begin
            if (state_q == NORMAL && cnt_inc == CMAX) begin
                state_d = FORCE;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    // Memory port mux; with no owner only the enables are dropped.
    always_comb begin
        bus.m_addr   = bus.p_addr;
        bus.m_wdata  = bus.p_wdata;
        bus.m_funct3 = bus.p_funct3;
        bus.m_rd     = 1'b0;
        bus.m_wr     = 1'b0;
        unique case (1'b1)
            d_own: begin
                bus.m_addr   = bus.d_addr;
                bus.m_wdata  = bus.d_wdata;
                bus.m_funct3 = 3'b010;
                bus.m_wr     = bus.d_we;
                bus.m_rd     = ~bus.d_we;
            end
            p_own: begin
                bus.m_wr = bus.p_wr;
                bus.m_rd = bus.p_rd & ~bus.p_wr;
            end
            default: ;
        endcase
    end

    // State, counter and captured debug read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= NORMAL;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= d_own & ~bus.d_we;
            if (d_own & ~bus.d_we) begin
                rdata_q <= bus.m_rdata;
            end
        end
    end

    assign bus.p_rdata  = bus.m_rdata;
    assign bus.p_stall  = stall;
    assign bus.d_gnt    = d_own;
    assign bus.d_rdata  = rdata_q;
    assign bus.d_rvalid = rvalid_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: driver queues expected port values
// and debug read data, a negedge monitor pops and compares.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;

    dmem_arbiter_if #(.DATA_W(32), .DM_ADDRESS(9)) bus ();

    dmem_arbiter #(.DATA_W(32), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        prd;
        logic        pwr;
        logic [8:0]  paddr;
        logic [31:0] pwdata;
        logic [2:0]  pf3;
        logic        dreq;
        logic        dwe;
        logic [8:0]  daddr;
        logic [31:0] dwdata;
    } in_t;

    typedef struct packed {
        logic        stall;
        logic        gnt;
        logic        rd;
        logic        wr;
        logic [8:0]  addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic        rchk;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rv_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_n = 0;

    logic [31:0] mem [0:127];

    // Memory model: preloaded during reset, word writes afterwards.
    always @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 128; k++) mem[k] <= 32'h0;
            mem[4] <= 32'hDEADBEEF;
            mem[1] <= 32'h0BADF00D;
        end else if (bus.m_wr) begin
            mem[bus.m_addr[8:2]] <= bus.m_wdata;
        end
    end

    assign bus.m_rdata = mem[bus.m_addr[8:2]];

    task automatic cyc(input logic rst, input in_t i, input exp_t e);
        @(posedge clk);
        #1;
        reset        = rst;
        bus.p_rd     = i.prd;
        bus.p_wr     = i.pwr;
        bus.p_addr   = i.paddr;
        bus.p_wdata  = i.pwdata;
        bus.p_funct3 = i.pf3;
        bus.d_req    = i.dreq;
        bus.d_we     = i.dwe;
        bus.d_addr   = i.daddr;
        bus.d_wdata  = i.dwdata;
        exp_q.push_back(e);
    endtask

    exp_t        me;
    logic [47:0] got, want;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            cyc_n++;
            got  = {bus.p_stall, bus.d_gnt, bus.m_rd, bus.m_wr,
                    bus.m_addr, bus.m_funct3, bus.m_wdata};
            want = {me.stall, me.gnt, me.rd, me.wr,
                    me.addr, me.f3, me.wdata};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL port cyc%0d got %h want %h", cyc_n, got, want);
            end
            if (me.rchk) begin
                checks++;
                if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL rst_out cyc%0d rvalid %b rdata %h want 0 0",
                             cyc_n, bus.d_rvalid, bus.d_rdata);
                end
            end
        end
        if (bus.d_rvalid === 1'b1) begin
            checks++;
            if (rv_q.size() == 0) begin
                errors++;
                $display("FAIL rvalid cyc%0d unexpected pulse rdata %h",
                         cyc_n, bus.d_rdata);
            end else begin
                logic [31:0] w;
                w = rv_q.pop_front();
                if (bus.d_rdata !== w) begin
                    errors++;
                    $display("FAIL rdata cyc%0d got %h want %h",
                             cyc_n, bus.d_rdata, w);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        in_t st_rd, st_pl, st_wd;
        bus.p_rd = 0; bus.p_wr = 0; bus.p_addr = '0; bus.p_wdata = '0;
        bus.p_funct3 = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
        bus.d_wdata = '0;

        // reset held with traffic, then the first released cycle
        for (int n = 0; n < 3; n++)
            cyc(n == 2, in_t'{1, 1'b0 | 1'b1, 9'h0C, 32'hA5A5A5A5, 3'd2,
                              1, 0, 9'h10, 32'h0},
                exp_t'{0, 0, 0, 1, 9'h0C, 3'd2, 32'hA5A5A5A5, 1});
        // idle-slot debug read
        cyc(1, in_t'{0, 0, 9'h0, 32'h0, 3'd0, 1, 0, 9'h10, 32'h0},
            exp_t'{0, 1, 1, 0, 9'h10, 3'd2, 32'h0, 0});
        rv_q.push_back(32'hDEADBEEF);
        cyc(1, in_t'{0, 0, 9'h30, 32'h11, 3'd1, 0, 0, 9'h0, 32'h0},
            exp_t'{0, 0, 0, 0, 9'h30, 3'd1, 32'h11, 0});

        // starvation: four blocked cycles, then forced debug write
        st_wd = in_t'{1, 0, 9'h40, 32'h0, 3'd4, 1, 1, 9'h20, 32'h12345678};
        st_pl = in_t'{1, 0, 9'h40, 32'h0, 3'd4, 0, 0, 9'h0, 32'h0};
        st_rd = in_t'{1, 0, 9'h40, 32'h0, 3'd4, 1, 0, 9'h20, 32'h0};
        for (int n = 0; n < 4; n++)
            cyc(1, st_wd, exp_t'{0, 0, 1, 0, 9'h40, 3'd4, 32'h0, 0});
        cyc(1, st_wd, exp_t'{1, 1, 0, 1, 9'h20, 3'd2, 32'h12345678, 0});
        cyc(1, st_pl, exp_t'{0, 0, 1, 0, 9'h40, 3'd4, 32'h0, 0});

        // request withdrawn in the armed cycle: no stall, counter restarts
        for (int n = 0; n < 4; n++)
            cyc(1, st_rd, exp_t'{0, 0, 1, 0, 9'h40, 3'd4, 32'h0, 0});
        cyc(1, st_pl, exp_t'{0, 0, 1, 0, 9'h40, 3'd4, 32'h0, 0});
        for (int n = 0; n < 4; n++)
            cyc(1, st_rd, exp_t'{0, 0, 1, 0, 9'h40, 3'd4, 32'h0, 0});
        cyc(1, st_rd, exp_t'{1, 1, 1, 0, 9'h20, 3'd2, 32'h0, 0});
        rv_q.push_back(32'h12345678);
        cyc(1, st_pl, exp_t'{0, 0, 1, 0, 9'h40, 3'd4, 32'h0, 0});

        // pipeline read+write conflict: write wins, funct3 passes through
        cyc(1, in_t'{1, 1, 9'h08, 32'hCAFEF00D, 3'd0, 0, 0, 9'h0, 32'h0},
            exp_t'{0, 0, 0, 1, 9'h08, 3'd0, 32'hCAFEF00D, 0});

        // back-to-back debug read then write at 0x04
        cyc(1, in_t'{0, 0, 9'h0, 32'h0, 3'd0, 1, 0, 9'h04, 32'h0},
            exp_t'{0, 1, 1, 0, 9'h04, 3'd2, 32'h0, 0});
        rv_q.push_back(32'h0BADF00D);
        cyc(1, in_t'{0, 0, 9'h0, 32'h0, 3'd0, 1, 1, 9'h04, 32'h55AA55AA},
            exp_t'{0, 1, 0, 1, 9'h04, 3'd2, 32'h55AA55AA, 0});
        cyc(1, in_t'{0, 0, 9'h0, 32'h0, 3'd0, 0, 0, 9'h0, 32'h0},
            exp_t'{0, 0, 0, 0, 9'h0, 3'd0, 32'h0, 0});
        cyc(1, in_t'{0, 0, 9'h0, 32'h0, 3'd0, 1, 0, 9'h04, 32'h0},
            exp_t'{0, 1, 1, 0, 9'h04, 3'd2, 32'h0, 0});
        rv_q.push_back(32'h55AA55AA);
        cyc(1, in_t'{0, 0, 9'h0, 32'h0, 3'd0, 0, 0, 9'h0, 32'h0},
            exp_t'{0, 0, 0, 0, 9'h0, 3'd0, 32'h0, 0});

        // reset asserted in the forced cycle: stall released at once
        for (int n = 0; n < 4; n++)
            cyc(1, st_wd, exp_t'{0, 0, 1, 0, 9'h40, 3'd4, 32'h0, 0});
        cyc(0, st_wd, exp_t'{0, 0, 1, 0, 9'h40, 3'd4, 32'h0, 1});
        cyc(1, st_pl, exp_t'{0, 0, 1, 0, 9'h40, 3'd4, 32'h0, 1});

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || rv_q.size() != 0) begin
            errors++;
            $display("FAIL drain port_left %0d rdata_left %0d want 0 0",
                     exp_q.size(), rv_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
